// File: rtl/ann_seq_pkg.sv
// Shared types and CSR map for the ANN layer sequencer.
package ann_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } seq_state_e;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_STATUS = 3'd1;
    localparam logic [2:0] CSR_N_IN   = 3'd2;
    localparam logic [2:0] CSR_N_OUT  = 3'd3;
    localparam logic [2:0] CSR_CYCLES = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;

endpackage

// File: rtl/ann_seq_csr.sv
// Avalon-MM CSR slave for the ANN layer sequencer: layer sizes, control,
// sticky status with write-one-to-clear, registered read data and IRQ.
module ann_seq_csr
    import ann_seq_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              busy,
    input  logic              done_set,
    input  logic [31:0]       cycles,
    output logic              start_go,
    output logic              irq,
    output logic              irq_en,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] n_in,
    output logic [ADDR_W-1:0] n_out
);

    logic        wr_ctrl;
    logic        wr_status;
    logic        start_cmd;
    logic        sizes_ok;
    logic        start_zero;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign wr_ctrl    = avs_write && (avs_address == CSR_CTRL);
    assign wr_status  = avs_write && (avs_address == CSR_STATUS);
    assign start_cmd  = wr_ctrl && avs_writedata[CTRL_START];
    assign sizes_ok   = (n_in != '0) && (n_out != '0);
    assign start_go   = start_cmd && !busy && sizes_ok;
    // A start with an empty layer finishes immediately and flags the error.
    assign start_zero = start_cmd && !busy && !sizes_ok;
    assign irq        = done & irq_en;
    assign unused_wdata = ^avs_writedata[31:ADDR_W];

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            CSR_CTRL:   rd_mux = {30'd0, irq_en, 1'b0};
            CSR_STATUS: rd_mux = {29'd0, err, done, busy};
            CSR_N_IN:   rd_mux = 32'(n_in);
            CSR_N_OUT:  rd_mux = 32'(n_out);
            CSR_CYCLES: rd_mux = cycles;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_en       <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            n_in         <= ADDR_W'(1);
            n_out        <= ADDR_W'(1);
            avs_readdata <= '0;
        end else begin
            if (wr_ctrl)
                irq_en <= avs_writedata[CTRL_IRQ_EN];
            done <= done_set | start_zero | (done & ~(wr_status & avs_writedata[STAT_DONE]));
            err  <= start_zero | (err & ~(wr_status & avs_writedata[STAT_ERR]));
            if (avs_write && (avs_address == CSR_N_IN) && !busy)
                n_in <= avs_writedata[ADDR_W-1:0];
            if (avs_write && (avs_address == CSR_N_OUT) && !busy)
                n_out <= avs_writedata[ADDR_W-1:0];
            avs_readdata <= avs_read ? rd_mux : '0;
        end
    end

endmodule

// File: rtl/ann_layer_sequencer.sv
// Fully-connected layer sequencer: walks input/weight RAMs, drives the MAC and
// writes one result per neuron. Optional LED status mirror via LED_STATUS_EN.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | clear accumulator for current neuron
// ISSUE | one input/weight read per cycle
// DRAIN | wait for RAM and MAC pipeline to empty
// WRITE | store accumulator to output RAM
// DONE  | last neuron written, flag done
module ann_layer_sequencer
    import ann_seq_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 16,
    parameter int MAC_LAT = 3,
    parameter int RAM_LAT = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [2:0]         avs_address,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    input  logic               avs_read,
    output logic [31:0]        avs_readdata,
    output logic               irq,
    output logic [ADDR_W-1:0]  in_addr,
    output logic [WADDR_W-1:0] w_addr,
    output logic               mac_clr,
    output logic               mac_en,
    output logic               mac_last,
    output logic               out_we,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [7:0]         leds_export
);

    localparam int DRAIN_N = MAC_LAT + RAM_LAT;
    localparam int DW      = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;

    seq_state_e        state;
    logic [31:0]       cycles;
    logic              busy;
    logic              done_set;
    logic              start_go;
    logic              irq_en;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] n_in;
    logic [ADDR_W-1:0] n_out;
    logic [ADDR_W-1:0] neuron;
    logic [DW-1:0]     drain_cnt;
    logic              issue_v;
    logic              issue_last;

    assign busy     = (state != IDLE);
    assign done_set = (state == DONE);

    ann_seq_csr #(.ADDR_W(ADDR_W)) u_csr (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .busy          (busy),
        .done_set      (done_set),
        .cycles        (cycles),
        .start_go      (start_go),
        .irq           (irq),
        .irq_en        (irq_en),
        .done          (done),
        .err           (err),
        .n_in          (n_in),
        .n_out         (n_out)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            cycles     <= '0;
            in_addr    <= '0;
            w_addr     <= '0;
            neuron     <= '0;
            drain_cnt  <= '0;
            mac_clr    <= 1'b0;
            issue_v    <= 1'b0;
            issue_last <= 1'b0;
            out_we     <= 1'b0;
            out_addr   <= '0;
        end else begin
            mac_clr    <= 1'b0;
            issue_v    <= 1'b0;
            issue_last <= 1'b0;
            out_we     <= 1'b0;
            if (busy && (cycles != '1))
                cycles <= cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        state   <= CLR;
                        mac_clr <= 1'b1;
                        neuron  <= '0;
                        w_addr  <= '0;
                        cycles  <= '0;
                    end
                end
                CLR: begin
                    state      <= ISSUE;
                    in_addr    <= '0;
                    issue_v    <= 1'b1;
                    issue_last <= (n_in == ADDR_W'(1));
                end
                ISSUE: begin
                    // w_addr keeps running across neurons: neuron*N_IN + i.
                    w_addr <= w_addr + WADDR_W'(1);
                    if (in_addr == n_in - ADDR_W'(1)) begin
                        state     <= DRAIN;
                        drain_cnt <= DW'(DRAIN_N - 1);
                    end else begin
                        in_addr    <= in_addr + ADDR_W'(1);
                        issue_v    <= 1'b1;
                        issue_last <= (in_addr + ADDR_W'(1) == n_in - ADDR_W'(1));
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= WRITE;
                        out_we   <= 1'b1;
                        out_addr <= neuron;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                WRITE: begin
                    if (neuron == n_out - ADDR_W'(1)) begin
                        state <= DONE;
                    end else begin
                        state   <= CLR;
                        neuron  <= neuron + ADDR_W'(1);
                        mac_clr <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // MAC strobes follow the read issue by the RAM read latency.
    generate
        if (RAM_LAT == 0) begin : g_no_delay
            assign mac_en   = issue_v;
            assign mac_last = issue_last;
        end else begin : g_delay
            logic [RAM_LAT-1:0] en_sr;
            logic [RAM_LAT-1:0] last_sr;
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    en_sr   <= '0;
                    last_sr <= '0;
                end else begin
                    en_sr[0]   <= issue_v;
                    last_sr[0] <= issue_last;
                    for (int k = 1; k < RAM_LAT; k++) begin
                        en_sr[k]   <= en_sr[k-1];
                        last_sr[k] <= last_sr[k-1];
                    end
                end
            end
            assign mac_en   = en_sr[RAM_LAT-1];
            assign mac_last = last_sr[RAM_LAT-1];
        end
    endgenerate

`ifdef LED_STATUS_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            leds_export <= 8'h00;
        else
            leds_export <= {err, done, busy, irq_en, neuron[3:0]};
    end
`else
    logic unused_status;
    assign unused_status = ^{err, done, irq_en};
    assign leds_export   = 8'h00;
`endif

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Bench for ann_layer_sequencer: run-level timeline model plus directed CSR scenarios.
module tb_ann_layer_sequencer;

    localparam int MAC_LAT = 3;
    localparam int RAM_LAT = 1;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [9:0]  in_addr;
    logic [15:0] w_addr;
    logic        mac_clr;
    logic        mac_en;
    logic        mac_last;
    logic        out_we;
    logic [9:0]  out_addr;
    logic [7:0]  leds_export;

    int checks = 0;
    int errors = 0;
    int cnt_clr = 0, cnt_en = 0, cnt_last = 0, cnt_we = 0;

    ann_layer_sequencer #(.ADDR_W(10), .WADDR_W(16), .MAC_LAT(MAC_LAT), .RAM_LAT(RAM_LAT)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .in_addr       (in_addr),
        .w_addr        (w_addr),
        .mac_clr       (mac_clr),
        .mac_en        (mac_en),
        .mac_last      (mac_last),
        .out_we        (out_we),
        .out_addr      (out_addr),
        .leds_export   (leds_export)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    // Model: a run is a timeline t = 0.. after the start edge; each neuron
    // occupies N_IN+MAC_LAT+RAM_LAT+2 cycles, then one DONE cycle.
    bit m_busy = 0, m_done = 0, m_err = 0, m_irq_en = 0;
    int m_t = 0, m_cyc = 0, m_nin = 0, m_nout = 0;
    int r_nin = 1, r_nout = 1;
    int m_per;
    bit m_fin, m_go, m_zero, m_w1c, m_start;

    assign m_per   = m_nin + MAC_LAT + RAM_LAT + 2;
    assign m_fin   = m_busy && (m_t == m_nout * m_per);
    assign m_start = avs_write && (avs_address == 3'd0) && avs_writedata[0];
    assign m_go    = m_start && !m_busy && r_nin != 0 && r_nout != 0;
    assign m_zero  = m_start && !m_busy && (r_nin == 0 || r_nout == 0);
    assign m_w1c   = avs_write && (avs_address == 3'd1);

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            m_busy <= 0; m_done <= 0; m_err <= 0; m_irq_en <= 0;
            m_t <= 0; m_cyc <= 0; r_nin <= 1; r_nout <= 1;
        end else begin
            if (m_busy) begin
                m_t   <= m_t + 1;
                m_cyc <= m_cyc + 1;
            end
            if (m_fin) m_busy <= 0;
            if (m_go) begin
                m_busy <= 1; m_t <= 0; m_cyc <= 0;
                m_nin <= r_nin; m_nout <= r_nout;
            end
            m_done <= m_fin || m_zero || (m_done && !(m_w1c && avs_writedata[1]));
            m_err  <= m_zero || (m_err && !(m_w1c && avs_writedata[2]));
            if (avs_write && avs_address == 3'd0) m_irq_en <= avs_writedata[1];
            if (avs_write && avs_address == 3'd2 && !m_busy) r_nin <= int'(avs_writedata[9:0]);
            if (avs_write && avs_address == 3'd3 && !m_busy) r_nout <= int'(avs_writedata[9:0]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        int n, k;
        bit e_clr, e_iss, e_en, e_last, e_we;
        e_clr = 0; e_iss = 0; e_en = 0; e_last = 0; e_we = 0; n = 0; k = 0;
        if (!reset_reset_n) begin
            chk("rst_outs", {mac_clr, mac_en, mac_last, out_we, irq}, 0);
            chk("rst_addr", {in_addr, w_addr}, 0);
            chk("rst_oaddr", 32'(out_addr), 0);
            chk("rst_rdata", avs_readdata, 0);
            chk("rst_leds", 32'(leds_export), 0);
        end else begin
            if (m_busy && m_t < m_nout * m_per) begin
                n = m_t / m_per;
                k = m_t % m_per;
                e_clr  = (k == 0);
                e_iss  = (k >= 1 && k <= m_nin);
                e_en   = (k >= 1 + RAM_LAT && k <= m_nin + RAM_LAT);
                e_last = (k == m_nin + RAM_LAT);
                e_we   = (k == m_per - 1);
            end
            chk("mac_clr", 32'(mac_clr), 32'(e_clr));
            chk("mac_en", 32'(mac_en), 32'(e_en));
            chk("mac_last", 32'(mac_last), 32'(e_last));
            chk("out_we", 32'(out_we), 32'(e_we));
            chk("irq", 32'(irq), 32'(m_done & m_irq_en));
            if (e_iss) begin
                chk("in_addr", 32'(in_addr), k - 1);
                chk("w_addr", 32'(w_addr), n * m_nin + k - 1);
            end
            if (e_we) chk("out_addr", 32'(out_addr), n);
`ifdef LED_STATUS_EN
            if (m_busy && m_t >= 1)
                chk("leds_neuron", 32'(leds_export[3:0]),
                    (((m_t - 1) / m_per) < m_nout ? ((m_t - 1) / m_per) : m_nout - 1) % 16);
`else
            chk("leds_zero", 32'(leds_export), 0);
`endif
            cnt_clr  += int'(mac_clr);
            cnt_en   += int'(mac_en);
            cnt_last += int'(mac_last);
            cnt_we   += int'(out_we);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk_clk); #1;
        avs_write = 1'b0; avs_writedata = '0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        bit ok;
        ok = 0; s = '0;
        for (int k = 0; k < 300; k++) begin
            csr_rd(3'd1, s);
            if (s[0] == 1'b0 && s[1] == 1'b1) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout, status 0x%0h expected 0x2", name, s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int c0, e0, l0, w0;
        bit seen;
        reset_reset_n = 1'b0;
        avs_address = '0; avs_write = 0; avs_writedata = '0; avs_read = 0;
        fork
            forever begin
                @(negedge clk_clk);
                cmp_cycle();
            end
        join_none
        repeat (3) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;

        csr_rd(3'd1, r); chk("reset_status", r, 32'h0);
        csr_rd(3'd2, r); chk("reset_n_in", r, 32'd1);
        csr_rd(3'd3, r); chk("reset_n_out", r, 32'd1);
        csr_rd(3'd4, r); chk("reset_cycles", r, 32'd0);

        // 4 inputs, 2 neurons
        csr_wr(3'd2, 32'd4);
        csr_wr(3'd3, 32'd2);
        c0 = cnt_clr; e0 = cnt_en; l0 = cnt_last; w0 = cnt_we;
        csr_wr(3'd0, 32'h1);
        wait_done("run_4x2");
        csr_rd(3'd4, r); chk("cycles_4x2", r, 32'd21);
        chk("cycles_model", r, m_cyc);
        csr_rd(3'd1, r); chk("status_4x2", r, 32'h2);
        chk("n_clr_4x2", cnt_clr - c0, 2);
        chk("n_en_4x2", cnt_en - e0, 8);
        chk("n_last_4x2", cnt_last - l0, 2);
        chk("n_we_4x2", cnt_we - w0, 2);
        chk("last_out_addr", 32'(out_addr), 1);
        csr_wr(3'd1, 32'h6);

        // empty layer
        csr_wr(3'd2, 32'd0);
        e0 = cnt_en; w0 = cnt_we; c0 = cnt_clr;
        csr_wr(3'd0, 32'h1);
        csr_rd(3'd1, r); chk("status_zero", r, 32'h6);
        chk("zero_no_en", cnt_en - e0, 0);
        chk("zero_no_we", cnt_we - w0, 0);
        chk("zero_no_clr", cnt_clr - c0, 0);
        csr_wr(3'd1, 32'h6);
        csr_rd(3'd1, r); chk("status_w1c", r, 32'h0);

        // irq with 1x1 layer
        csr_wr(3'd2, 32'd1);
        csr_wr(3'd3, 32'd1);
        csr_wr(3'd0, 32'h2);
        csr_wr(3'd0, 32'h3);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_clk); #1;
            if (irq) begin seen = 1; break; end
        end
        chk("irq_rise", 32'(seen), 32'd1);
        csr_wr(3'd1, 32'h2);
        chk("irq_fall", 32'(irq), 32'd0);
        // W1C of done landing on the DONE edge: set must win
        csr_wr(3'd0, 32'h3);
        repeat (7) @(posedge clk_clk);
        #1;
        csr_wr(3'd1, 32'h2);
        csr_rd(3'd1, r); chk("w1c_vs_set", r, 32'h2);
        chk("irq_held", 32'(irq), 32'd1);
        csr_wr(3'd1, 32'h6);
        csr_wr(3'd0, 32'h0);

        // start and N_IN write while busy are ignored
        csr_wr(3'd2, 32'd3);
        csr_wr(3'd3, 32'd2);
        csr_wr(3'd0, 32'h1);
        repeat (2) @(posedge clk_clk);
        #1;
        csr_wr(3'd0, 32'h1);
        csr_wr(3'd2, 32'd7);
        wait_done("run_busy_writes");
        csr_rd(3'd2, r); chk("n_in_kept", r, 32'd3);
        csr_rd(3'd4, r); chk("cycles_3x2", r, 32'd19);
        csr_rd(3'd1, r); chk("status_no_err", r, 32'h2);
        csr_wr(3'd1, 32'h6);

        // five neurons
        csr_wr(3'd2, 32'd1);
        csr_wr(3'd3, 32'd5);
        w0 = cnt_we;
        csr_wr(3'd0, 32'h1);
        wait_done("run_1x5");
        csr_rd(3'd4, r); chk("cycles_1x5", r, 32'd36);
        chk("n_we_1x5", cnt_we - w0, 5);
        csr_wr(3'd1, 32'h6);

        // async reset during ISSUE, then a clean run
        csr_wr(3'd2, 32'd3);
        csr_wr(3'd3, 32'd2);
        csr_wr(3'd0, 32'h1);
        repeat (3) @(posedge clk_clk);
        #1;
        chk("pre_rst_in_addr", 32'(in_addr), 32'd2);
        chk("pre_rst_w_addr", 32'(w_addr), 32'd2);
        reset_reset_n = 1'b0;
        #1;
        chk("rst_in_addr", 32'(in_addr), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_strobes", {mac_clr, mac_en, mac_last, out_we}, 32'd0);
        repeat (2) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;
        csr_rd(3'd2, r); chk("post_rst_n_in", r, 32'd1);
        csr_wr(3'd2, 32'd2);
        csr_wr(3'd3, 32'd3);
        csr_wr(3'd0, 32'h1);
        wait_done("run_after_reset");
        csr_rd(3'd4, r); chk("cycles_2x3", r, 32'd25);
        csr_rd(3'd1, r); chk("status_2x3", r, 32'h2);

        repeat (2) @(posedge clk_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
